// File: rtl/riscv_mem_responder.sv
// Word-organised RAM that serves the RISCV32I fetch and data ports over req/gnt/rvalid, LATENCY wait cycles.
// Define RISCV_MEM_BYTE_STROBE_EN to add the d_be byte-lane store strobes.
module riscv_mem_responder #(
  parameter int XLEN       = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
`ifdef RISCV_MEM_BYTE_STROBE_EN
  input  logic [XLEN/8-1:0] d_be,
`endif
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err
);

  localparam int NB    = XLEN / 8;
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  isData_q;
  logic                  we_q;
  logic                  fault_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [XLEN-1:0]       wdata_q;
  logic [NB-1:0]         be_q;

  logic [XLEN-1:0]       mem [WORDS];

  logic                  accept;
  logic [XLEN-1:0]       selAddr;
  logic [DEPTH_LOG2-1:0] selIdx;
  logic                  selFault;
  logic [NB-1:0]         beIn;

`ifdef RISCV_MEM_BYTE_STROBE_EN
  assign beIn = d_be;
`else
  assign beIn = '1;
`endif

  // The RESP cycle may also accept, so a new grant lands in the cycle right after the response.
  always_comb begin
    accept   = ((state_q == IDLE) || (state_q == RESP)) && (d_req || i_req);
    selAddr  = d_req ? d_addr : i_addr;
    selIdx   = selAddr[DEPTH_LOG2+1:2];
    selFault = (selAddr[1:0] != 2'b00) || ((selAddr >> (DEPTH_LOG2 + 2)) != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      isData_q <= 1'b0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      i_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      i_err    <= 1'b0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      i_gnt <= 1'b0;
      d_gnt <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          i_rvalid <= 1'b0;
          d_rvalid <= 1'b0;
          i_rdata  <= '0;
          d_rdata  <= '0;
          i_err    <= 1'b0;
          d_err    <= 1'b0;
          state_q  <= IDLE;
          if (accept) begin
            d_gnt    <= d_req;
            i_gnt    <= !d_req;
            isData_q <= d_req;
            we_q     <= d_req && d_we;
            fault_q  <= selFault;
            idx_q    <= selIdx;
            wdata_q  <= d_wdata;
            be_q     <= beIn;
            cnt_q    <= 4'(LATENCY);
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= RESP;
            i_rvalid <= !isData_q;
            d_rvalid <= isData_q;
            i_err    <= !isData_q && fault_q;
            d_err    <= isData_q && fault_q;
            if (!fault_q && !we_q) begin
              if (isData_q) d_rdata <= mem[idx_q];
              else          i_rdata <= mem[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stores commit on the edge that ends RESP; a reset before then leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && isData_q && we_q && !fault_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule
